// File: rtl/bit_insertion_16x32_seq.sv
// bit_insertion_16x32_seq
//   Reassembles narrow NoC egress slices into full-width words. Each accepted
//   slice is deposited at bit offset i_cmd of an accumulation word. The merged
//   word and a coverage mask are emitted one cycle later, either when a slice
//   carries i_last or when every bit of the word has been written.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   i_valid     slice present this cycle
//   i_en        block enable; a slice is accepted only when i_valid & i_en
//   i_data_bus  slice data (IN_DATA_WIDTH bits)
//   i_cmd       bit offset k; slice lands on word bits [k+IN_DATA_WIDTH-1:k]
//   i_last      close the word after this slice
//   o_valid     one-cycle pulse; o_data_bus / o_mask valid
//   o_data_bus  assembled word, unwritten bits are 0
//   o_mask      1 = bit written by some slice of this word
//   o_err       one-cycle pulse: an accepted slice had an out-of-range i_cmd
module bit_insertion_16x32_seq #(
   parameter int DATA_WIDTH    = 32,
   parameter int IN_DATA_WIDTH = DATA_WIDTH >> 1,
   parameter int COMMAND_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_valid,
   input  logic                     i_en,
   input  logic [IN_DATA_WIDTH-1:0] i_data_bus,
   input  logic [COMMAND_WIDTH-1:0] i_cmd,
   input  logic                     i_last,
   output logic                     o_valid,
   output logic [DATA_WIDTH-1:0]    o_data_bus,
   output logic [DATA_WIDTH-1:0]    o_mask,
   output logic                     o_err
);

   localparam int MAX_CMD = DATA_WIDTH - IN_DATA_WIDTH;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t                  state_q;
   logic [DATA_WIDTH-1:0]   acc_q;
   logic [DATA_WIDTH-1:0]   acc_mask_q;
   logic                    o_valid_q;
   logic                    o_err_q;
   logic [DATA_WIDTH-1:0]   o_data_q;
   logic [DATA_WIDTH-1:0]   o_mask_q;

   logic                    accept;
   logic                    cmd_legal;
   logic [DATA_WIDTH-1:0]   base_acc;
   logic [DATA_WIDTH-1:0]   base_mask;
   logic [DATA_WIDTH-1:0]   slice_sh;
   logic [DATA_WIDTH-1:0]   field_sh;
   logic [DATA_WIDTH-1:0]   acc_d;
   logic [DATA_WIDTH-1:0]   acc_mask_d;
   logic                    close;

   assign accept    = i_valid & i_en;
   assign cmd_legal = (i_cmd <= COMMAND_WIDTH'(MAX_CMD));

   // In IDLE the accumulator is empty by construction, so the merge base is
   // forced to zero rather than trusting the stored word.
   assign base_acc  = (state_q == FILL) ? acc_q      : '0;
   assign base_mask = (state_q == FILL) ? acc_mask_q : '0;

   // Slice and its field mask are zero-extended before shifting, so high bits
   // fall off the top and nothing wraps into the LSBs.
   assign slice_sh = DATA_WIDTH'(i_data_bus) << i_cmd;
   assign field_sh = DATA_WIDTH'({IN_DATA_WIDTH{1'b1}}) << i_cmd;

   always_comb begin
      acc_d      = base_acc;
      acc_mask_d = base_mask;
      if (cmd_legal) begin
         // Later slice overwrites earlier bits; coverage only accumulates.
         acc_d      = (base_acc & ~field_sh) | slice_sh;
         acc_mask_d = base_mask | field_sh;
      end
   end

   assign close = accept & (i_last | (acc_mask_d == {DATA_WIDTH{1'b1}}));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         acc_mask_q <= '0;
         o_valid_q  <= 1'b0;
         o_err_q    <= 1'b0;
         o_data_q   <= '0;
         o_mask_q   <= '0;
      end else begin
         o_valid_q <= 1'b0;
         o_err_q   <= 1'b0;
         if (accept) begin
            o_err_q <= ~cmd_legal;
            if (close) begin
               o_valid_q  <= 1'b1;
               o_data_q   <= acc_d;
               o_mask_q   <= acc_mask_d;
               acc_q      <= '0;
               acc_mask_q <= '0;
               state_q    <= IDLE;
            end else begin
               acc_q      <= acc_d;
               acc_mask_q <= acc_mask_d;
               // An illegal first slice leaves the word empty, so stay in IDLE.
               state_q    <= (acc_mask_d == '0) ? IDLE : FILL;
            end
         end
      end
   end

   assign o_valid    = o_valid_q;
   assign o_err      = o_err_q;
   assign o_data_bus = o_data_q;
   assign o_mask     = o_mask_q;

endmodule

// File: tb/tb_bit_insertion_16x32_seq.sv
// tb_bit_insertion_16x32_seq
//   Directed bench for bit_insertion_16x32_seq. Inputs change on the falling
//   edge; outputs are sampled on the falling edge, so each sample reflects the
//   slice driven one step earlier.
module tb_bit_insertion_16x32_seq;

   logic        clk;
   logic        rst_n;
   logic        i_valid;
   logic        i_en;
   logic [15:0] i_data_bus;
   logic [4:0]  i_cmd;
   logic        i_last;
   logic        o_valid;
   logic [31:0] o_data_bus;
   logic [31:0] o_mask;
   logic        o_err;

   int checks;
   int failures;

   bit_insertion_16x32_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_valid    (i_valid),
      .i_en       (i_en),
      .i_data_bus (i_data_bus),
      .i_cmd      (i_cmd),
      .i_last     (i_last),
      .o_valid    (o_valid),
      .o_data_bus (o_data_bus),
      .o_mask     (o_mask),
      .o_err      (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Wait for the falling edge, then drive one cycle of inputs.
   task automatic step(input logic v, input logic en, input logic [15:0] d,
                       input logic [4:0] c, input logic l);
      @(negedge clk);
      i_valid    = v;
      i_en       = en;
      i_data_bus = d;
      i_cmd      = c;
      i_last     = l;
   endtask

   task automatic idle();
      step(1'b0, 1'b1, 16'h0000, 5'd0, 1'b0);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      rst_n      = 1'b0;
      i_valid    = 1'b0;
      i_en       = 1'b0;
      i_data_bus = '0;
      i_cmd      = '0;
      i_last     = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_err",   {31'd0, o_err},   32'd0);
      chk("rst_data",  o_data_bus, 32'h0);
      chk("rst_mask",  o_mask,     32'h0);
      rst_n = 1'b1;

      // Single slice at offset 4 with i_last
      step(1'b1, 1'b1, 16'hFFFF, 5'd4, 1'b1);
      idle();
      chk("off4_valid", {31'd0, o_valid}, 32'd1);
      chk("off4_data",  o_data_bus, 32'h000FFFF0);
      chk("off4_mask",  o_mask,     32'h000FFFF0);
      chk("off4_err",   {31'd0, o_err}, 32'd0);
      idle();
      chk("off4_pulse_width", {31'd0, o_valid}, 32'd0);
      chk("off4_hold_data",   o_data_bus, 32'h000FFFF0);

      // Auto-close once both halves are written
      step(1'b1, 1'b1, 16'h1234, 5'd0, 1'b0);
      step(1'b1, 1'b1, 16'hABCD, 5'd16, 1'b0);
      chk("auto_first_novalid", {31'd0, o_valid}, 32'd0);
      idle();
      chk("auto_valid", {31'd0, o_valid}, 32'd1);
      chk("auto_data",  o_data_bus, 32'hABCD1234);
      chk("auto_mask",  o_mask,     32'hFFFFFFFF);

      // Overlap: later slice wins
      step(1'b1, 1'b1, 16'h00FF, 5'd0, 1'b0);
      step(1'b1, 1'b1, 16'hA5A5, 5'd8, 1'b1);
      idle();
      chk("ovl_valid", {31'd0, o_valid}, 32'd1);
      chk("ovl_data",  o_data_bus, 32'h00A5A5FF);
      chk("ovl_mask",  o_mask,     32'h00FFFFFF);

      // Async reset mid-FILL discards the partial word
      step(1'b1, 1'b1, 16'h1234, 5'd0, 1'b0);
      idle();
      chk("fill_novalid", {31'd0, o_valid}, 32'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_data",  o_data_bus, 32'h0);
      chk("arst_mask",  o_mask,     32'h0);
      chk("arst_valid", {31'd0, o_valid}, 32'd0);
      #1 rst_n = 1'b1;
      step(1'b1, 1'b1, 16'hABCD, 5'd16, 1'b1);
      idle();
      chk("post_rst_valid", {31'd0, o_valid}, 32'd1);
      chk("post_rst_data",  o_data_bus, 32'hABCD0000);
      chk("post_rst_mask",  o_mask,     32'hFFFF0000);

      // Illegal offset with i_last on an empty word
      step(1'b1, 1'b1, 16'hBEEF, 5'd17, 1'b1);
      idle();
      chk("ill_valid", {31'd0, o_valid}, 32'd1);
      chk("ill_err",   {31'd0, o_err},   32'd1);
      chk("ill_data",  o_data_bus, 32'h0);
      chk("ill_mask",  o_mask,     32'h0);
      idle();
      chk("ill_err_clear",   {31'd0, o_err},   32'd0);
      chk("ill_valid_clear", {31'd0, o_valid}, 32'd0);

      // Streaming with an i_en=0 cycle between pairs
      step(1'b1, 1'b1, 16'h1111, 5'd0, 1'b0);
      step(1'b1, 1'b1, 16'h2222, 5'd16, 1'b0);
      chk("strm_s1_novalid", {31'd0, o_valid}, 32'd0);
      step(1'b1, 1'b0, 16'hFFFF, 5'd0, 1'b1);
      chk("strm_p1_valid", {31'd0, o_valid}, 32'd1);
      chk("strm_p1_data",  o_data_bus, 32'h22221111);
      chk("strm_p1_mask",  o_mask,     32'hFFFFFFFF);
      step(1'b1, 1'b1, 16'h3333, 5'd0, 1'b0);
      chk("strm_hold_novalid", {31'd0, o_valid}, 32'd0);
      chk("strm_hold_noerr",   {31'd0, o_err},   32'd0);
      chk("strm_hold_data",    o_data_bus, 32'h22221111);
      step(1'b1, 1'b1, 16'h4444, 5'd16, 1'b0);
      chk("strm_s3_novalid", {31'd0, o_valid}, 32'd0);
      idle();
      chk("strm_p2_valid", {31'd0, o_valid}, 32'd1);
      chk("strm_p2_data",  o_data_bus, 32'h44443333);
      chk("strm_p2_mask",  o_mask,     32'hFFFFFFFF);
      idle();
      chk("strm_end_novalid", {31'd0, o_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
